fetch_sequencer: RTL and testbench

Sequences instruction fetch for the core. It owns the architectural PC, runs a request/acknowledge handshake with instruction memory, and hands fetched instructions to decode under a stall backpressure. It accepts resolved branch/jump results from the execute-stage branch unit (taken flag plus target PC), redirects fetch, flushes the in-flight instruction and traps on misaligned targets.

---
 rtl/fetch_sequencer_pkg.sv | 15 +
 rtl/fetch_stats_counter.sv | 31 +++
 rtl/fetch_sequencer.sv | 135 +++++++++++++
 tb/tb_fetch_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encoding,
// default reset PC and instruction width.
package fetch_sequencer_pkg;

    localparam int unsigned INSTR_W          = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_TRAP  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_stats_counter.sv
// Saturating pair of branch-event counters: all resolved branches and taken
// branches. Counting stops while en is low.
module fetch_stats_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        inc_all,
    input  logic        inc_taken,
    output logic [31:0] br_count,
    output logic [31:0] br_taken_count
);

    logic [31:0] all_q;
    logic [31:0] taken_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            all_q   <= '0;
            taken_q <= '0;
        end else if (en) begin
            if (inc_all && (all_q != '1))
                all_q <= all_q + 32'd1;
            if (inc_taken && (taken_q != '1))
                taken_q <= taken_q + 32'd1;
        end
    end

    assign br_count       = all_q;
    assign br_taken_count = taken_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, handshakes with instruction memory,
// presents instructions to decode and handles branch redirects / misaligned traps.
// Optional branch statistics outputs are enabled by FETCH_SEQ_STATS_EN.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        instr_pc,
    input  logic               b_valid,
    input  logic               b_taken,
    input  logic [31:0]        b_pc,
    output logic               flush,
`ifdef FETCH_SEQ_STATS_EN
    output logic [31:0]        br_count,
    output logic [31:0]        br_taken_count,
`endif
    output logic               trap,
    output logic [31:0]        trap_pc
);

    fetch_state_e       state_q;
    logic [31:0]        pc_q;
    logic [31:0]        drain_addr_q;
    logic               run_q;
    logic [INSTR_W-1:0] instr_q;
    logic [31:0]        instr_pc_q;
    logic               instr_valid_q;
    logic               flush_q;
    logic               trap_q;
    logic [31:0]        trap_pc_q;

    logic redirect;
    logic misaligned;

    assign redirect   = b_valid && b_taken && (state_q != ST_TRAP);
    assign misaligned = (b_pc[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            drain_addr_q  <= '0;
            run_q         <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            trap_q        <= 1'b0;
            trap_pc_q     <= '0;
        end else begin
            run_q   <= 1'b1;
            flush_q <= redirect;
            if (redirect) begin
                instr_valid_q <= 1'b0;
                if (misaligned) begin
                    state_q   <= ST_TRAP;
                    trap_q    <= 1'b1;
                    trap_pc_q <= b_pc;
                end else begin
                    pc_q <= b_pc;
                    // An ack arriving with the redirect retires the dropped request.
                    case (state_q)
                        ST_FETCH: begin
                            if (!imem_ack) begin
                                state_q      <= ST_DRAIN;
                                drain_addr_q <= pc_q;
                            end
                        end
                        ST_DRAIN: begin
                            if (imem_ack)
                                state_q <= ST_FETCH;
                        end
                        default: state_q <= ST_FETCH;
                    endcase
                end
            end else begin
                case (state_q)
                    ST_FETCH: begin
                        if (imem_ack) begin
                            instr_q       <= imem_rdata;
                            instr_pc_q    <= pc_q;
                            pc_q          <= pc_q + 32'd4;
                            instr_valid_q <= 1'b1;
                            state_q       <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (!stall) begin
                            instr_valid_q <= 1'b0;
                            state_q       <= ST_FETCH;
                        end
                    end
                    ST_DRAIN: begin
                        if (imem_ack)
                            state_q <= ST_FETCH;
                    end
                    default: ;
                endcase
            end
        end
    end

    // While draining, the abandoned request stays on the bus at its old address.
    assign imem_req    = run_q && ((state_q == ST_FETCH) || (state_q == ST_DRAIN));
    assign imem_addr   = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign flush       = flush_q;
    assign trap        = trap_q;
    assign trap_pc     = trap_pc_q;

`ifdef FETCH_SEQ_STATS_EN
    fetch_stats_counter u_stats (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (state_q != ST_TRAP),
        .inc_all        (b_valid),
        .inc_taken      (b_valid && b_taken),
        .br_count       (br_count),
        .br_taken_count (br_taken_count)
    );
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized
// memory/stall/branch traffic checked against a transaction-level model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        b_valid = 1'b0;
    logic        b_taken = 1'b0;
    logic [31:0] b_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        flush;
    logic        trap;
    logic [31:0] trap_pc;

    logic        w_ack = 1'b0;
    logic [31:0] w_rdata = '0;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_ipc;
    logic        w_flush;
    logic        w_trap;
    logic [31:0] w_trap_pc;

`ifdef FETCH_SEQ_STATS_EN
    logic [31:0] br_count, br_taken_count, w_brc, w_brt;
`endif

    always #5 clk = ~clk;

    fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .b_valid(b_valid), .b_taken(b_taken), .b_pc(b_pc),
        .flush(flush),
`ifdef FETCH_SEQ_STATS_EN
        .br_count(br_count), .br_taken_count(br_taken_count),
`endif
        .trap(trap), .trap_pc(trap_pc)
    );

    fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(rst_n), .stall(1'b0),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_ack), .imem_rdata(w_rdata),
        .instr_valid(w_valid), .instr(w_instr), .instr_pc(w_ipc),
        .b_valid(1'b0), .b_taken(1'b0), .b_pc(32'h0),
        .flush(w_flush),
`ifdef FETCH_SEQ_STATS_EN
        .br_count(w_brc), .br_taken_count(w_brt),
`endif
        .trap(w_trap), .trap_pc(w_trap_pc)
    );

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;

    // Reference model: what the fetch unit is doing, in transaction terms.
    bit          m_run;        // a clock edge has passed since reset release
    logic [31:0] m_pc;         // next address to fetch
    bit          m_have;       // an instruction is being offered to decode
    logic [31:0] m_instr, m_ipc;
    bit          m_drop;       // an old request is still open and its data is unwanted
    logic [31:0] m_drop_addr;
    bit          m_trap;
    logic [31:0] m_trap_pc;
    bit          m_flush;
    logic [31:0] m_brc, m_brt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic bit exp_req();
        return m_run && !m_have && !m_trap;
    endfunction

    task automatic model_reset();
        m_run = 0; m_pc = 32'h0; m_have = 0; m_instr = '0; m_ipc = '0;
        m_drop = 0; m_drop_addr = '0; m_trap = 0; m_trap_pc = '0; m_flush = 0;
        m_brc = '0; m_brt = '0;
    endtask

    task automatic model_edge();
        bit redirect;
        bit was_have;
        redirect = b_valid && b_taken && !m_trap;
        was_have = m_have;
        if (!m_trap) begin
            if (b_valid && m_brc != 32'hFFFF_FFFF) m_brc = m_brc + 1;
            if (b_valid && b_taken && m_brt != 32'hFFFF_FFFF) m_brt = m_brt + 1;
        end
        m_flush = redirect;
        if (redirect) begin
            m_have = 0;
            if (b_pc % 4 != 0) begin
                m_trap = 1; m_trap_pc = b_pc; m_drop = 0;
            end else begin
                if (!was_have && !imem_ack) begin
                    if (!m_drop) m_drop_addr = m_pc;
                    m_drop = 1;
                end else begin
                    m_drop = 0;
                end
                m_pc = b_pc;
            end
        end else if (!m_trap) begin
            if (m_have) begin
                if (!stall) m_have = 0;
            end else if (imem_ack) begin
                if (m_drop) m_drop = 0;
                else begin
                    m_have = 1; m_instr = imem_rdata; m_ipc = m_pc; m_pc = m_pc + 4;
                end
            end
        end
        m_run = 1;
    endtask

    task automatic check_outputs();
        chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req()});
        if (exp_req())
            chk("imem_addr", imem_addr, m_drop ? m_drop_addr : m_pc);
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_have});
        chk("instr", instr, m_instr);
        chk("instr_pc", instr_pc, m_ipc);
        chk("flush", {31'b0, flush}, {31'b0, m_flush});
        chk("trap", {31'b0, trap}, {31'b0, m_trap});
        chk("trap_pc", trap_pc, m_trap_pc);
`ifdef FETCH_SEQ_STATS_EN
        chk("br_count", br_count, m_brc);
        chk("br_taken_count", br_taken_count, m_brt);
`endif
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic a, input logic s, input logic bv, input logic bt,
                        input logic [31:0] bp, input logic [31:0] rd);
        check_outputs();
        imem_ack = a; stall = s; b_valid = bv; b_taken = bt; b_pc = bp; imem_rdata = rd;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle(input logic s);
        step(1'b0, s, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Asserts reset between clock edges (possibly mid-request); ends at a falling edge.
    task automatic reset_dut();
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_outputs();
        imem_ack = 0; stall = 0; b_valid = 0; b_taken = 0; b_pc = '0; w_ack = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rand_step();
        logic a, s, bv, bt;
        logic [31:0] bp;
        a  = exp_req() ? 1'($urandom_range(0, 1)) : 1'b0;
        s  = 1'($urandom_range(0, 1));
        bv = ($urandom_range(0, 5) == 0);
        bt = 1'($urandom_range(0, 1));
        bp = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 15) == 0) bp[1:0] = 2'($urandom_range(1, 3));
        step(a, s, bv, bt, bp, $urandom);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        reset_dut();

        // First fetch: ack two cycles into the request
        idle(1'b0);
        idle(1'b0);
        idle(1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0013);
        chk("first_valid", {31'b0, instr_valid}, 32'd1);
        chk("first_instr", instr, 32'h0000_0013);
        chk("first_pc", instr_pc, 32'h0);
        // Stall for three cycles, then release
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("stall_hold_instr", instr, 32'h0000_0013);
        chk("stall_no_req", {31'b0, imem_req}, 32'd0);
        idle(1'b0);
        chk("next_addr", imem_addr, 32'h4);

        // Fetch 4, consume, then redirect while request to 8 is pending
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h1111_0004);
        idle(1'b0);
        chk("addr8", imem_addr, 32'h8);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0);
        chk("redir_flush", {31'b0, flush}, 32'd1);
        chk("drain_addr", imem_addr, 32'h8);
        idle(1'b0);
        chk("flush_one_cycle", {31'b0, flush}, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF);
        chk("drain_no_valid", {31'b0, instr_valid}, 32'd0);
        chk("post_drain_addr", imem_addr, 32'h100);

        // Misaligned redirect traps until reset
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h102, 32'h0);
        chk("trap_set", {31'b0, trap}, 32'd1);
        chk("trap_pc", trap_pc, 32'h102);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 32'h0);
        chk("trap_no_req", {31'b0, imem_req}, 32'd0);

`ifdef FETCH_SEQ_STATS_EN
        reset_dut();
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h80, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h44, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h88, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h8C, 32'h0);
        chk("stats_all", br_count, 32'd5);
        chk("stats_taken", br_taken_count, 32'd2);
`endif

        // PC wrap on the second instance (main instance left idle)
        reset_dut();
        @(negedge clk);
        chk("wrap_req0", {31'b0, w_req}, 32'd1);
        chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        w_ack = 1; w_rdata = 32'hAAAA_0001;
        @(negedge clk);
        w_ack = 0;
        chk("wrap_ipc0", w_ipc, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("wrap_addr1", w_addr, 32'h0);
        w_ack = 1; w_rdata = 32'hAAAA_0002;
        @(negedge clk);
        w_ack = 0;
        chk("wrap_ipc1", w_ipc, 32'h0);
        chk("wrap_instr1", w_instr, 32'hAAAA_0002);

        // Randomized traffic with asynchronous resets mid-stream
        for (int e = 0; e < 6; e++) begin
            reset_dut();
            for (int i = 0; i < 250; i++) begin
                if (i == 125) reset_dut();
                rand_step();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
